seven_seg_scanner: RTL

//  Time-multiplexed 8-digit seven-segment driver. Sits downstream of the Time block.

---
 rtl/seven_seg_scanner.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed 8-digit seven-segment driver. Scans one digit per slot of
//   SCAN_DIV clocks, blanking all anodes for the first BLANK_CYCLES clocks of a
//   slot to prevent ghosting. A full frame (8 slots) is shown from one snapshot
//   of i_Time/i_PM, taken as the last slot of the previous frame ends. Digit 7
//   (hours tens) is suppressed when zero; any digit with its i_Blink_Mask bit
//   set is hidden during the odd blink phase (phase flips every
//   BLINK_HALF_PERIOD 100 Hz pulses).
//
//   Optional feature: define SEVEN_SEG_BRIGHTNESS_EN to add i_Brightness[2:0],
//   which shortens the lit part of each slot to (b+1)/8 of the post-blank time.
//
// Ports
//   i_Clk_5MHz        system clock
//   i_Reset_N         asynchronous active-low reset
//   i_Clk_100Hz_Pulse one-clock 100 Hz strobe (blink timebase)
//   i_Time            8 BCD digits, [31:28]=digit 7 .. [3:0]=digit 0
//   i_PM              PM flag, shown on digit 0 decimal point
//   i_Blink_Mask      bit n set: digit n blinks
//   i_Display_En      0 forces all anodes off
//   i_Brightness      (SEVEN_SEG_BRIGHTNESS_EN only) brightness 0..7
//   o_Anodes          active-low digit enables, bit n = digit n
//   o_Segments        active-low {g,f,e,d,c,b,a}
//   o_DP              active-low decimal point
module seven_seg_scanner #(
  parameter int unsigned SCAN_DIV          = 625,
  parameter int unsigned BLANK_CYCLES      = 16,
  parameter int unsigned BLINK_HALF_PERIOD = 50
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset_N,
  input  logic        i_Clk_100Hz_Pulse,
  input  logic [31:0] i_Time,
  input  logic        i_PM,
  input  logic [7:0]  i_Blink_Mask,
  input  logic        i_Display_En,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
  input  logic [2:0]  i_Brightness,
`endif
  output logic [7:0]  o_Anodes,
  output logic [6:0]  o_Segments,
  output logic        o_DP
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_HALF_PERIOD + 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_time_q, snap_time_d;
  logic          snap_pm_q, snap_pm_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [7:0]    anodes_q, anodes_d;
  logic [6:0]    segments_q, segments_d;
  logic          dp_q, dp_d;

  logic          slot_last;
  logic          slot_start;
  logic          digit_blank;
  logic          lit_window;
  logic [3:0]    cur_digit;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
  localparam int unsigned LW    = PW + 4;
  localparam int unsigned SLICE = (SCAN_DIV - BLANK_CYCLES) / 8;
  logic [2:0]    bright_q, bright_d;
  logic [LW-1:0] lit_end;
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_last  = (pre_q == PW'(SCAN_DIV - 1));
    slot_start = (pre_q == '0);
    cur_digit  = snap_time_q[{idx_q, 2'b00} +: 4];

    // Scan counters; snapshot taken as the last slot of a frame ends so the
    // next frame is drawn from one consistent value.
    pre_d       = pre_q + 1'b1;
    idx_d       = idx_q;
    snap_time_d = snap_time_q;
    snap_pm_d   = snap_pm_q;
    if (slot_last) begin
      pre_d = '0;
      idx_d = idx_q + 1'b1;
      if (idx_q == 3'd7) begin
        snap_time_d = i_Time;
        snap_pm_d   = i_PM;
      end
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (i_Clk_100Hz_Pulse) begin
      if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    digit_blank = ((idx_q == 3'd7) && (snap_time_q[31:28] == 4'd0)) ||
                  (i_Blink_Mask[idx_q] && blink_phase_q);

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    bright_d   = slot_start ? i_Brightness : bright_q;
    lit_end    = LW'(BLANK_CYCLES) + LW'(SLICE) * LW'({1'b0, bright_q} + 4'd1);
    lit_window = ({4'b0000, pre_q} < lit_end);
`else
    lit_window = 1'b1;
`endif

    if ((pre_q >= PW'(BLANK_CYCLES)) && i_Display_En && !digit_blank && lit_window)
      anodes_d = ~(8'b0000_0001 << idx_q);
    else
      anodes_d = '1;

    // Cathodes change only at slot start, inside the all-anodes-off window.
    segments_d = segments_q;
    dp_d       = dp_q;
    if (slot_start) begin
      segments_d = seg_decode(cur_digit);
      dp_d       = !((idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2) ||
                     ((idx_q == 3'd0) && snap_pm_q));
    end
  end

  always_ff @(posedge i_Clk_5MHz or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      pre_q         <= '0;
      idx_q         <= '0;
      snap_time_q   <= '0;
      snap_pm_q     <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      anodes_q      <= '1;
      segments_q    <= '1;
      dp_q          <= 1'b1;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      bright_q      <= '0;
`endif
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_time_q   <= snap_time_d;
      snap_pm_q     <= snap_pm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      dp_q          <= dp_d;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
      bright_q      <= bright_d;
`endif
    end
  end

  assign o_Anodes   = anodes_q;
  assign o_Segments = segments_q;
  assign o_DP       = dp_q;

endmodule
